id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register, directly downstream of the decode-stage stall/bubble mux.
//  Captures the muxed control bundle and decode datapath values, and presents them to EX.
//  Supports three actions:
//  - hold on a global memory/cache stall;
//  - zero-bubble on branch flush, with a flush raised during a hold kept pending;
//  - a saturating bubble counter for performance debug.
// PARAMETERS
//  DATA_W   32  width of register-file operands, immediate and PC+4
//  REG_AW    5  register index width
//  CNT_W    16  bubble counter width
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        synchronous active-low reset
//  mem_stall     in   1        global stall (cache miss); freeze all state
//  flush         in   1        branch-taken flush of the ID instruction
//  RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, ALUSrc_in, RegDst_in  in  1 each  control from stall mux
//  ALUop_in      in   2        ALU op class from stall mux
//  pc4_in        in   DATA_W   PC+4 of ID instruction
//  rs_data_in    in   DATA_W   register-file read port A
//  rt_data_in    in   DATA_W   register-file read port B
//  imm_in        in   DATA_W   sign-extended immediate
//  rs_in, rt_in, rd_in  in  REG_AW  register indices
//  RegWrite_ex, MemtoReg_ex, Branch_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex, RegDst_ex  out  1 each  registered controls
//  ALUop_ex      out  2        registered ALU op
//  pc4_ex, rs_data_ex, rt_data_ex, imm_ex   out  DATA_W  registered datapath values
//  rs_ex, rt_ex, rd_ex    out  REG_AW  registered indices (forwarding and hazard use)
//  valid_ex      out  1        1 = real instruction in EX, 0 = bubble
//  bubble_cnt    out  CNT_W    count of bubble cycles loaded, saturating
// BEHAVIOUR
//  - Clock and reset: single clock; reset is synchronous and active-low.
//  - Reset, when rst_n=0 at a rising edge: every output goes to 0, including ALUop_ex=2'b00, valid_ex=0 and bubble_cnt=0; flush_pend=0.
//  - Priority per edge: reset > mem_stall > (flush | flush_pend) > normal load.
//  - mem_stall=1: all outputs and bubble_cnt hold their values.
//    - If flush=1 during the stall, set flush_pend=1. It stays set until it is applied.
//  - mem_stall=0 and (flush | flush_pend): load a bubble.
//    - All control outputs go to 0, including MemWrite_ex=0 and ALUop_ex=2'b00.
//    - valid_ex=0.
//    - Datapath and index outputs go to 0.
//    - Clear flush_pend.
//    - bubble_cnt += 1.
//  - Otherwise, normal load: capture all *_in values.
//    - valid_ex = RegWrite_in | MemRead_in | MemWrite_in | Branch_in.
//    - If valid_ex would be 0 (the upstream mux inserted a bubble), the control outputs are still copied verbatim, and bubble_cnt += 1.
//  - Latency: 1 cycle from input to output, with no combinational path from in to out.
//  - bubble_cnt saturates at all-ones; it does not wrap.
//  - A flush that arrives together with the mem_stall release is applied in that same cycle; it is counted once.
//  - Reset in the middle of a hold or with a flush pending: reset wins and flush_pend is cleared.
//  - No X propagation: every flop is reset.
// STRUCTURE
//  - Shared package: the ctrl bundle width (CTRL_W=9) and the ALUop encodings (2'b00 add, 2'b01 sub/branch, 2'b10 R-type).
//  - One natural submodule: pipe_field_reg #(W), a W-bit register with sync rst_n, hold and clear.
//    Instantiate it separately for the ctrl, pc4, rs_data, rt_data, imm and index fields.
//  - flush_pend and the bubble counter live at the top level.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0 and bubble_cnt=0. Release -> the next edge loads the inputs.
//  2. Normal flow: R-type (RegWrite=1, RegDst=1, ALUop=2'b10, rs_data=0x0000_0005) -> one cycle later the outputs match and valid_ex=1.
//  3. Hold: mem_stall=1 for 3 cycles while the inputs change -> outputs frozen at the pre-stall values and bubble_cnt unchanged.
//  4. Flush during hold: mem_stall=1, flush pulsed in cycle 1, stall released in cycle 3 ->
//     in cycle 4 the outputs are all 0, valid_ex=0 and bubble_cnt +1 exactly once; in cycle 5 normal load resumes.
//  5. Upstream bubble: load the upstream bubble pattern (all controls 0 except ALUop=2'b10) ->
//     valid_ex=0, ALUop_ex=2'b10 and bubble_cnt +1.
//  6. Saturation: with CNT_W=4, flush for 20 cycles -> bubble_cnt stops at 4'hF. Then reset -> 0.

Source files
------------

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared ID/EX types: the decode control bundle and the ALU op-class encodings.
// Field order of ctrl_t is the bit order used everywhere the bundle is packed.
package id_ex_pipe_reg_pkg;

   localparam int CTRL_W = 9;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_RTYPE = 2'b10
   } alu_op_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
   } ctrl_t;

   // An instruction is real when it has any architectural side effect.
   function automatic logic is_real_instr(ctrl_t c);
      return c.reg_write | c.mem_read | c.mem_write | c.branch;
   endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX register; the master drives
// the decode side, the slave (the register) drives the EX side.
interface id_ex_pipe_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   import id_ex_pipe_reg_pkg::*;

   logic              mem_stall;
   logic              flush;
   logic              RegWrite_in, MemtoReg_in, Branch_in, MemRead_in;
   logic              MemWrite_in, ALUSrc_in, RegDst_in;
   logic [1:0]        ALUop_in;
   logic [DATA_W-1:0] pc4_in, rs_data_in, rt_data_in, imm_in;
   logic [REG_AW-1:0] rs_in, rt_in, rd_in;

   logic              RegWrite_ex, MemtoReg_ex, Branch_ex, MemRead_ex;
   logic              MemWrite_ex, ALUSrc_ex, RegDst_ex;
   logic [1:0]        ALUop_ex;
   logic [DATA_W-1:0] pc4_ex, rs_data_ex, rt_data_ex, imm_ex;
   logic [REG_AW-1:0] rs_ex, rt_ex, rd_ex;
   logic              valid_ex;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output mem_stall, flush,
      output RegWrite_in, MemtoReg_in, Branch_in, MemRead_in,
      output MemWrite_in, ALUSrc_in, RegDst_in, ALUop_in,
      output pc4_in, rs_data_in, rt_data_in, imm_in, rs_in, rt_in, rd_in,
      input  RegWrite_ex, MemtoReg_ex, Branch_ex, MemRead_ex,
      input  MemWrite_ex, ALUSrc_ex, RegDst_ex, ALUop_ex,
      input  pc4_ex, rs_data_ex, rt_data_ex, imm_ex, rs_ex, rt_ex, rd_ex,
      input  valid_ex, bubble_cnt
   );

   modport slave (
      input  mem_stall, flush,
      input  RegWrite_in, MemtoReg_in, Branch_in, MemRead_in,
      input  MemWrite_in, ALUSrc_in, RegDst_in, ALUop_in,
      input  pc4_in, rs_data_in, rt_data_in, imm_in, rs_in, rt_in, rd_in,
      output RegWrite_ex, MemtoReg_ex, Branch_ex, MemRead_ex,
      output MemWrite_ex, ALUSrc_ex, RegDst_ex, ALUop_ex,
      output pc4_ex, rs_data_ex, rt_data_ex, imm_ex, rs_ex, rt_ex, rd_ex,
      output valid_ex, bubble_cnt
   );

endinterface

// File: rtl/id_ex_pipe_reg_field.sv
// W-bit pipeline field: 1-cycle register, hold freezes it, clear loads zero.
// Priority: rst_n > hold > clr > load.
module pipe_field_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hold,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (!hold) begin
         q <= clr ? '0 : d;
      end
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: 1-cycle latency, no in-to-out combinational path.
// mem_stall freezes everything; a flush (or one deferred by a stall) loads a zero bubble.
module id_ex_pipe_reg
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic              clk,
   input logic              rst_n,
   id_ex_pipe_reg_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ctrl_t             ctrl_d, ctrl_q;
   logic [3*REG_AW-1:0] idx_q;
   logic              flush_pend;
   logic              bubble_ld;
   logic              valid_d;
   logic              cnt_inc;
   logic [CNT_W-1:0]  cnt_q;

   assign ctrl_d = {bus.RegWrite_in, bus.MemtoReg_in, bus.Branch_in, bus.MemRead_in,
                    bus.MemWrite_in, bus.ALUSrc_in, bus.RegDst_in, bus.ALUop_in};

   assign bubble_ld = !bus.mem_stall && (bus.flush || flush_pend);
   assign valid_d   = is_real_instr(ctrl_d);
   // A flush bubble and an upstream bubble in the same cycle count as one.
   assign cnt_inc   = !bus.mem_stall && (bubble_ld || !valid_d);

   pipe_field_reg #(.W(CTRL_W)) u_ctrl (
      .clk(clk), .rst_n(rst_n), .hold(bus.mem_stall), .clr(bubble_ld),
      .d(ctrl_d), .q(ctrl_q)
   );
   pipe_field_reg #(.W(DATA_W)) u_pc4 (
      .clk(clk), .rst_n(rst_n), .hold(bus.mem_stall), .clr(bubble_ld),
      .d(bus.pc4_in), .q(bus.pc4_ex)
   );
   pipe_field_reg #(.W(DATA_W)) u_rs_data (
      .clk(clk), .rst_n(rst_n), .hold(bus.mem_stall), .clr(bubble_ld),
      .d(bus.rs_data_in), .q(bus.rs_data_ex)
   );
   pipe_field_reg #(.W(DATA_W)) u_rt_data (
      .clk(clk), .rst_n(rst_n), .hold(bus.mem_stall), .clr(bubble_ld),
      .d(bus.rt_data_in), .q(bus.rt_data_ex)
   );
   pipe_field_reg #(.W(DATA_W)) u_imm (
      .clk(clk), .rst_n(rst_n), .hold(bus.mem_stall), .clr(bubble_ld),
      .d(bus.imm_in), .q(bus.imm_ex)
   );
   pipe_field_reg #(.W(3*REG_AW)) u_idx (
      .clk(clk), .rst_n(rst_n), .hold(bus.mem_stall), .clr(bubble_ld),
      .d({bus.rs_in, bus.rt_in, bus.rd_in}), .q(idx_q)
   );
   pipe_field_reg #(.W(1)) u_valid (
      .clk(clk), .rst_n(rst_n), .hold(bus.mem_stall), .clr(bubble_ld),
      .d(valid_d), .q(bus.valid_ex)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flush_pend <= 1'b0;
      end else if (bus.mem_stall) begin
         if (bus.flush) flush_pend <= 1'b1;
      end else begin
         flush_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign bus.RegWrite_ex = ctrl_q.reg_write;
   assign bus.MemtoReg_ex = ctrl_q.mem_to_reg;
   assign bus.Branch_ex   = ctrl_q.branch;
   assign bus.MemRead_ex  = ctrl_q.mem_read;
   assign bus.MemWrite_ex = ctrl_q.mem_write;
   assign bus.ALUSrc_ex   = ctrl_q.alu_src;
   assign bus.RegDst_ex   = ctrl_q.reg_dst;
   assign bus.ALUop_ex    = ctrl_q.alu_op;
   assign bus.rs_ex       = idx_q[3*REG_AW-1:2*REG_AW];
   assign bus.rt_ex       = idx_q[2*REG_AW-1:REG_AW];
   assign bus.rd_ex       = idx_q[REG_AW-1:0];
   assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: the driver pushes the expected EX state per edge,
// a negedge monitor pops and compares against the DUT outputs.
module tb_id_ex_pipe_reg;
   import id_ex_pipe_reg_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   typedef struct packed {
      logic [8:0]    ctrl;
      logic [DW-1:0] pc4, rsd, rtd, imm;
      logic [AW-1:0] rs, rt, rd;
      logic          valid;
      logic [CW-1:0] cnt;
   } out_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_pops = 0;
   out_t exp_q[$];

   // Reference state of the register, updated once per edge by tick().
   out_t m;
   logic m_pend;

   always #5 clk = ~clk;

   id_ex_pipe_reg_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

   id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   task automatic set_in(input ctrl_t c, input logic [DW-1:0] pc4, input logic [DW-1:0] rsd,
                         input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
      bus.RegWrite_in = c.reg_write;
      bus.MemtoReg_in = c.mem_to_reg;
      bus.Branch_in   = c.branch;
      bus.MemRead_in  = c.mem_read;
      bus.MemWrite_in = c.mem_write;
      bus.ALUSrc_in   = c.alu_src;
      bus.RegDst_in   = c.reg_dst;
      bus.ALUop_in    = c.alu_op;
      bus.pc4_in = pc4; bus.rs_data_in = rsd; bus.rt_data_in = rtd; bus.imm_in = imm;
      bus.rs_in = rs; bus.rt_in = rt; bus.rd_in = rd;
   endtask

   task automatic set_rand();
      logic [31:0] r;
      r = $urandom;
      set_in(ctrl_t'(r[8:0]), $urandom, $urandom, $urandom, $urandom,
             r[13:9], r[18:14], r[23:19]);
   endtask

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == 4'hF) ? v : v + 4'h1;
   endfunction

   // Advance the reference by one edge from the current inputs, then queue it.
   task automatic tick();
      logic [8:0] cin;
      cin = {bus.RegWrite_in, bus.MemtoReg_in, bus.Branch_in, bus.MemRead_in,
             bus.MemWrite_in, bus.ALUSrc_in, bus.RegDst_in, bus.ALUop_in};
      if (!rst_n) begin
         m = '0;
         m_pend = 1'b0;
      end else if (bus.mem_stall) begin
         if (bus.flush) m_pend = 1'b1;
      end else if (bus.flush || m_pend) begin
         m.ctrl = '0; m.pc4 = '0; m.rsd = '0; m.rtd = '0; m.imm = '0;
         m.rs = '0; m.rt = '0; m.rd = '0; m.valid = 1'b0;
         m.cnt = sat_inc(m.cnt);
         m_pend = 1'b0;
      end else begin
         m.ctrl = cin;
         m.pc4 = bus.pc4_in; m.rsd = bus.rs_data_in; m.rtd = bus.rt_data_in;
         m.imm = bus.imm_in; m.rs = bus.rs_in; m.rt = bus.rt_in; m.rd = bus.rd_in;
         m.valid = bus.RegWrite_in | bus.MemRead_in | bus.MemWrite_in | bus.Branch_in;
         if (!m.valid) m.cnt = sat_inc(m.cnt);
      end
      @(posedge clk);
      exp_q.push_back(m);
      #1;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: output is presented every cycle, compare at the falling edge.
   initial begin
      out_t a, e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.ctrl = {bus.RegWrite_ex, bus.MemtoReg_ex, bus.Branch_ex, bus.MemRead_ex,
                      bus.MemWrite_ex, bus.ALUSrc_ex, bus.RegDst_ex, bus.ALUop_ex};
            a.pc4 = bus.pc4_ex; a.rsd = bus.rs_data_ex; a.rtd = bus.rt_data_ex;
            a.imm = bus.imm_ex; a.rs = bus.rs_ex; a.rt = bus.rt_ex; a.rd = bus.rd_ex;
            a.valid = bus.valid_ex; a.cnt = bus.bubble_cnt;
            n_pops++;
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL ex_outputs[%0d]: got ctrl=%h pc4=%h rs=%h rt=%h imm=%h idx=%h/%h/%h v=%b cnt=%h expected ctrl=%h pc4=%h rs=%h rt=%h imm=%h idx=%h/%h/%h v=%b cnt=%h",
                        n_pops, a.ctrl, a.pc4, a.rsd, a.rtd, a.imm, a.rs, a.rt, a.rd, a.valid, a.cnt,
                        e.ctrl, e.pc4, e.rsd, e.rtd, e.imm, e.rs, e.rt, e.rd, e.valid, e.cnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete within 100000 time units");
      $fatal(1, "timeout");
   end

   initial begin
      ctrl_t c_lw, c_rtype, c_sw, c_ubub, c_beq;
      c_lw    = '{reg_write:1'b1, mem_to_reg:1'b1, branch:1'b0, mem_read:1'b1, mem_write:1'b0,
                  alu_src:1'b1, reg_dst:1'b0, alu_op:ALU_ADD};
      c_rtype = '{reg_write:1'b1, mem_to_reg:1'b0, branch:1'b0, mem_read:1'b0, mem_write:1'b0,
                  alu_src:1'b0, reg_dst:1'b1, alu_op:ALU_RTYPE};
      c_sw    = '{reg_write:1'b0, mem_to_reg:1'b0, branch:1'b0, mem_read:1'b0, mem_write:1'b1,
                  alu_src:1'b1, reg_dst:1'b0, alu_op:ALU_ADD};
      c_beq   = '{reg_write:1'b0, mem_to_reg:1'b0, branch:1'b1, mem_read:1'b0, mem_write:1'b0,
                  alu_src:1'b0, reg_dst:1'b0, alu_op:ALU_SUB};
      c_ubub  = '{reg_write:1'b0, mem_to_reg:1'b0, branch:1'b0, mem_read:1'b0, mem_write:1'b0,
                  alu_src:1'b0, reg_dst:1'b0, alu_op:ALU_RTYPE};
      m = '0;
      m_pend = 1'b0;
      bus.mem_stall = 1'b0;
      bus.flush = 1'b0;

      // Reset with random inputs, stall and flush asserted.
      rst_n = 1'b0;
      bus.mem_stall = 1'b1; bus.flush = 1'b1;
      set_rand(); tick();
      set_rand(); tick();
      check_val("reset_cnt", 32'(bus.bubble_cnt), 32'h0);
      check_val("reset_valid", 32'(bus.valid_ex), 32'h0);

      // Release: first edge loads a lw.
      rst_n = 1'b1; bus.mem_stall = 1'b0; bus.flush = 1'b0;
      set_in(c_lw, 32'h0000_0104, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0010, 5'd3, 5'd8, 5'd0);
      tick();
      check_val("release_load_valid", 32'(bus.valid_ex), 32'h1);

      // R-type.
      set_in(c_rtype, 32'h0000_0108, 32'h0000_0005, 32'h0000_0007, 32'h0000_0020, 5'd1, 5'd2, 5'd9);
      tick();
      check_val("rtype_rs_data", bus.rs_data_ex, 32'h0000_0005);
      check_val("rtype_aluop", 32'(bus.ALUop_ex), 32'h2);

      // Hold for 3 cycles with changing inputs.
      bus.mem_stall = 1'b1;
      set_in(c_sw, 32'h0000_010C, 32'h1111_1111, 32'h2222_2222, 32'h4, 5'd4, 5'd5, 5'd6); tick();
      set_in(c_ubub, 32'h0000_0110, 32'h3333_3333, 32'h4444_4444, 32'h8, 5'd7, 5'd8, 5'd9); tick();
      set_rand(); tick();
      check_val("hold_rs_data", bus.rs_data_ex, 32'h0000_0005);
      check_val("hold_cnt", 32'(bus.bubble_cnt), 32'h0);

      // Flush in stall cycle 1, stall released at cycle 3.
      set_in(c_sw, 32'h0000_0200, 32'hAAAA_0001, 32'hBBBB_0002, 32'hC, 5'd10, 5'd11, 5'd12);
      bus.flush = 1'b1; tick();
      bus.flush = 1'b0; tick();
      bus.mem_stall = 1'b0; tick();
      check_val("flush_pend_valid", 32'(bus.valid_ex), 32'h0);
      check_val("flush_pend_cnt", 32'(bus.bubble_cnt), 32'h1);
      set_in(c_sw, 32'h0000_0204, 32'hAAAA_0003, 32'hBBBB_0004, 32'h10, 5'd13, 5'd14, 5'd15);
      tick();
      check_val("resume_memwrite", 32'(bus.MemWrite_ex), 32'h1);

      // Flush arriving together with the stall release counts once.
      bus.mem_stall = 1'b1; tick();
      bus.mem_stall = 1'b0; bus.flush = 1'b1;
      set_in(c_beq, 32'h0000_0300, 32'h5, 32'h5, 32'hFFFF_FFF0, 5'd16, 5'd17, 5'd0); tick();
      bus.flush = 1'b0;
      check_val("release_flush_cnt", 32'(bus.bubble_cnt), 32'h2);
      tick();
      check_val("branch_valid", 32'(bus.valid_ex), 32'h1);

      // Upstream bubble: controls copied, valid low, counted.
      set_in(c_ubub, 32'h0000_0400, 32'h9, 32'hA, 32'hB, 5'd18, 5'd19, 5'd20); tick();
      check_val("ubub_aluop", 32'(bus.ALUop_ex), 32'h2);
      check_val("ubub_cnt", 32'(bus.bubble_cnt), 32'h3);

      // Reset during a hold with a flush pending clears the pending flush.
      bus.mem_stall = 1'b1; bus.flush = 1'b1; tick();
      bus.flush = 1'b0; rst_n = 1'b0; tick();
      rst_n = 1'b1; bus.mem_stall = 1'b0;
      set_in(c_lw, 32'h0000_0500, 32'h77, 32'h88, 32'h99, 5'd21, 5'd22, 5'd23); tick();
      check_val("post_reset_no_flush_valid", 32'(bus.valid_ex), 32'h1);
      check_val("post_reset_cnt", 32'(bus.bubble_cnt), 32'h0);

      // Saturation over 20 flushes, then reset.
      bus.flush = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_rand(); tick();
      end
      bus.flush = 1'b0;
      check_val("sat_cnt", 32'(bus.bubble_cnt), 32'hF);
      rst_n = 1'b0; tick();
      check_val("sat_reset_cnt", 32'(bus.bubble_cnt), 32'h0);
      rst_n = 1'b1;
      set_in(c_rtype, 32'h0000_0600, 32'h1, 32'h2, 32'h3, 5'd24, 5'd25, 5'd26); tick();

      @(negedge clk);
      #1;
      check_val("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
